// File: rtl/bus_master_if.sv
// Avalon-MM style bus initiator: arbitrates instruction fetches and data loads/stores onto one
// waitrequest-compliant bus, with byte/halfword lane steering, load extension and stall timeout.
module bus_master_if #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_done,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [1:0]  d_size,
   input  logic        d_signed,
   input  logic [31:0] d_wdata,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic [31:0] bus_address,
   output logic        bus_read,
   output logic        bus_write,
   output logic [3:0]  bus_byteenable,
   output logic [31:0] bus_writedata,
   input  logic        bus_waitrequest,
   input  logic [31:0] bus_readdata,
   output logic        timeout_err
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
      logic m;
      case (size)
         2'b00:   m = 1'b0;
         2'b01:   m = a[0];
         2'b10:   m = (a != 2'b00);
         default: m = 1'b1;
      endcase
      return m;
   endfunction

   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
      logic [3:0] be;
      case (size)
         2'b00:   be = 4'b0001 << a;
         2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
      logic [31:0] r;
      case (size)
         2'b00:   r = {4{wd[7:0]}};
         2'b01:   r = {2{wd[15:0]}};
         default: r = wd;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] a,
                                                input logic sgn, input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = rd[{a, 3'b000} +: 8];
      h = a[1] ? rd[31:16] : rd[15:0];
      case (size)
         2'b00:   r = {{24{sgn & b[7]}}, b};
         2'b01:   r = {{16{sgn & h[15]}}, h};
         default: r = rd;
      endcase
      return r;
   endfunction

   state_t        state_q, state_d;
   logic          data_own_q, data_own_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [1:0]    size_q, size_d;
   logic          signed_q, signed_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          err_q, err_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tmo_q, tmo_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         data_own_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         size_q     <= '0;
         signed_q   <= 1'b0;
         be_q       <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         cnt_q      <= '0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_own_q <= data_own_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         signed_q   <= signed_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      data_own_d = data_own_q;
      we_d       = we_q;
      addr_d     = addr_q;
      size_d     = size_q;
      signed_d   = signed_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      case (state_q)
         IDLE: begin
            cnt_d   = '0;
            rdata_d = '0;
            if (d_req) begin
               data_own_d = 1'b1;
               we_d       = d_we;
               addr_d     = d_addr;
               size_d     = d_size;
               signed_d   = d_signed;
               be_d       = lane_be(d_size, d_addr[1:0]);
               wdata_d    = lane_wdata(d_size, d_wdata);
               err_d      = misaligned(d_size, d_addr[1:0]);
               state_d    = ISSUE;
            end else if (i_req) begin
               data_own_d = 1'b0;
               we_d       = 1'b0;
               addr_d     = i_addr;
               size_d     = 2'b10;
               signed_d   = 1'b0;
               be_d       = 4'b1111;
               wdata_d    = '0;
               err_d      = 1'b0;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            // A misaligned access spends its ISSUE cycle with strobes suppressed, keeping latency uniform.
            if (err_q) begin
               state_d = RESP;
            end else if (bus_waitrequest) begin
               if (cnt_q == CNT_LAST) begin
                  err_d   = 1'b1;
                  tmo_d   = 1'b1;
                  rdata_d = '0;
                  state_d = RESP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               rdata_d = we_q ? '0 : load_extract(size_q, addr_q[1:0], signed_q, bus_readdata);
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   logic issuing;
   logic in_resp;
   assign issuing        = (state_q == ISSUE) && !err_q;
   assign in_resp        = (state_q == RESP);
   assign bus_read       = issuing && !we_q;
   assign bus_write      = issuing && we_q;
   assign bus_address    = {addr_q[31:2], 2'b00};
   assign bus_byteenable = issuing ? be_q : 4'b0000;
   assign bus_writedata  = wdata_q;
   assign i_done         = in_resp && !data_own_q;
   assign d_done         = in_resp && data_own_q;
   assign i_rdata        = i_done ? rdata_q : 32'h0;
   assign d_rdata        = d_done ? rdata_q : 32'h0;
   assign d_err          = d_done && err_q;
   assign timeout_err    = tmo_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Randomized scoreboard bench for bus_master_if: a driver pushes expected bus beats and responses,
// a responder model serves the bus, and a monitor pops and compares whenever the DUT presents output.
module tb_bus_master_if;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, d_req, d_we, d_signed;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [1:0]  d_size;
   logic        i_done, d_done, d_err;
   logic [31:0] i_rdata, d_rdata;
   logic [31:0] bus_address, bus_writedata, bus_readdata;
   logic        bus_read, bus_write, bus_waitrequest;
   logic [3:0]  bus_byteenable;
   logic        timeout_err;

   always #5 clk = ~clk;

   bus_master_if #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size), .d_signed(d_signed),
      .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
      .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
      .bus_byteenable(bus_byteenable), .bus_writedata(bus_writedata),
      .bus_waitrequest(bus_waitrequest), .bus_readdata(bus_readdata),
      .timeout_err(timeout_err)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      int          cycles;
   } bus_exp_t;

   typedef struct {
      logic        is_data;
      logic [31:0] rdata;
      logic        err;
      logic        tmo;
   } resp_exp_t;

   typedef struct {
      int          waits;
      logic [31:0] rd;
   } slave_t;

   bus_exp_t  exp_bus[$];
   resp_exp_t exp_resp[$];
   slave_t    slave_q[$];
   logic      model_tmo = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: event not expected / not seen", name);
   endtask

   // ---------------- reference model ----------------
   function automatic bit m_misal(input int size, input logic [31:0] addr);
      return (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
   endfunction

   function automatic logic [3:0] m_be(input int size, input logic [31:0] addr);
      if (size == 0) return 4'(1 << (addr % 4));
      if (size == 1) return (addr % 4 >= 2) ? 4'd12 : 4'd3;
      return 4'd15;
   endfunction

   function automatic logic [31:0] m_wd(input int size, input logic [31:0] wd);
      if (size == 0) return (wd & 32'hFF) * 32'h0101_0101;
      if (size == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] m_load(input int size, input logic [31:0] addr,
                                          input bit sgn, input logic [31:0] rd);
      logic [31:0] v;
      if (size == 0) begin
         v = (rd >> (8 * (addr % 4))) & 32'hFF;
         if (sgn && v >= 128) v = v | 32'hFFFF_FF00;
      end else if (size == 1) begin
         v = (rd >> (8 * ((addr % 4) & 2))) & 32'hFFFF;
         if (sgn && v >= 32768) v = v | 32'hFFFF_0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   // Pushes expectations for a data access and returns the latency it should have.
   task automatic plan_data(input bit we, input logic [31:0] addr, input int size, input bit sgn,
                            input logic [31:0] wd, input int waits, input logic [31:0] rd,
                            output int lat);
      bit mis, tmo;
      mis = m_misal(size, addr);
      tmo = !mis && waits >= TMO;
      if (!mis) begin
         exp_bus.push_back('{we, addr & 32'hFFFF_FFFC, m_be(size, addr), m_wd(size, wd),
                             tmo ? TMO : waits + 1});
         slave_q.push_back('{waits, rd});
      end
      if (tmo) model_tmo = 1'b1;
      exp_resp.push_back('{1'b1, (mis || we || tmo) ? 32'h0 : m_load(size, addr, sgn, rd),
                           mis || tmo, model_tmo});
      lat = mis ? 2 : (tmo ? TMO + 1 : waits + 2);
   endtask

   task automatic plan_fetch(input logic [31:0] addr, input int waits, input logic [31:0] rd,
                             output int lat);
      bit tmo;
      tmo = waits >= TMO;
      exp_bus.push_back('{1'b0, addr & 32'hFFFF_FFFC, 4'hF, 32'h0, tmo ? TMO : waits + 1});
      slave_q.push_back('{waits, rd});
      if (tmo) model_tmo = 1'b1;
      exp_resp.push_back('{1'b0, tmo ? 32'h0 : rd, 1'b0, model_tmo});
      lat = tmo ? TMO + 1 : waits + 2;
   endtask

   task automatic wait_done(input bit data, output int lat);
      lat = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         lat++;
         if (data ? d_done : i_done) return;
      end
      fail("done_wait_expired");
   endtask

   task automatic data_txn(input bit we, input logic [31:0] addr, input int size, input bit sgn,
                           input logic [31:0] wd, input int waits, input logic [31:0] rd);
      int exp_lat, lat;
      plan_data(we, addr, size, sgn, wd, waits, rd, exp_lat);
      @(negedge clk);
      d_we = we; d_addr = addr; d_size = 2'(size); d_signed = sgn; d_wdata = wd; d_req = 1'b1;
      wait_done(1'b1, lat);
      d_req = 1'b0;
      chk("data_latency", lat, exp_lat);
   endtask

   task automatic fetch_txn(input logic [31:0] addr, input int waits, input logic [31:0] rd);
      int exp_lat, lat;
      plan_fetch(addr, waits, rd, exp_lat);
      @(negedge clk);
      i_addr = addr; i_req = 1'b1;
      wait_done(1'b0, lat);
      i_req = 1'b0;
      chk("fetch_latency", lat, exp_lat);
   endtask

   // ---------------- responder ----------------
   initial begin
      slave_t cur;
      bit     active;
      active = 1'b0;
      cur = '{0, 32'h0};
      bus_waitrequest = 1'b0;
      bus_readdata = 32'h0;
      forever begin
         @(negedge clk);
         if (bus_read || bus_write) begin
            if (!active) begin
               if (slave_q.size() > 0) cur = slave_q.pop_front();
               else cur = '{0, 32'h0};
               active = 1'b1;
            end
            bus_waitrequest = (cur.waits > 0);
            if (cur.waits > 0) cur.waits--;
            bus_readdata = cur.rd;
         end else begin
            active = 1'b0;
            bus_waitrequest = 1'($urandom_range(0, 1));
            bus_readdata = $urandom;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      bus_exp_t  cb;
      resp_exp_t re;
      bit        prev, have, stb;
      int        ncyc;
      prev = 1'b0; have = 1'b0; ncyc = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev = 1'b0;
            have = 1'b0;
            continue;
         end
         stb = bus_read || bus_write;
         if (stb && !prev) begin
            ncyc = 0;
            if (exp_bus.size() == 0) begin
               fail("unexpected_strobe");
               have = 1'b0;
            end else begin
               cb = exp_bus.pop_front();
               have = 1'b1;
            end
         end
         if (stb && have) begin
            chk("bus_write", bus_write, cb.wr);
            chk("bus_read", bus_read, !cb.wr);
            chk("bus_address", bus_address, cb.addr);
            chk("bus_byteenable", bus_byteenable, cb.be);
            if (cb.wr) chk("bus_writedata", bus_writedata, cb.wd);
            ncyc++;
         end
         if (!stb && prev && have) begin
            chk("strobe_cycles", ncyc, cb.cycles);
            have = 1'b0;
         end
         prev = stb;
         if (i_done && d_done) begin
            fail("both_done");
         end else if (i_done || d_done) begin
            chk("strobe_in_resp", {bus_read, bus_write}, 2'b00);
            if (exp_resp.size() == 0) begin
               fail("unexpected_done");
            end else begin
               re = exp_resp.pop_front();
               chk("done_port", d_done, re.is_data);
               if (re.is_data) begin
                  chk("d_rdata", d_rdata, re.rdata);
                  chk("d_err", d_err, re.err);
               end else begin
                  chk("i_rdata", i_rdata, re.rdata);
               end
               chk("timeout_err", timeout_err, re.tmo);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int lat_d, lat_f, el_d, el_f;
      bit seen;
      reset = 1'b1;
      i_req = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_size = 2'b00; d_signed = 1'b0; d_wdata = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_outputs", {i_done, d_done, d_err, bus_read, bus_write, bus_byteenable, timeout_err}, 0);
      chk("rst_rdata", i_rdata | d_rdata | bus_address, 32'h0);
      reset = 1'b0;

      fetch_txn(32'hBFC0_0000, 1, 32'h2402_000A);
      data_txn(1'b0, 32'h0000_0013, 0, 1'b1, 32'h0, 0, 32'h80FF_1234);
      data_txn(1'b0, 32'h0000_0013, 0, 1'b0, 32'h0, 2, 32'h80FF_1234);
      data_txn(1'b1, 32'h0000_0012, 1, 1'b0, 32'hDEAD_BEEF, 0, 32'h0);
      data_txn(1'b0, 32'h0000_0006, 2, 1'b0, 32'h0, 0, 32'h1234_5678);
      data_txn(1'b0, 32'h0000_0022, 1, 1'b1, 32'h0, 1, 32'hF00D_8001);

      // Simultaneous requests: data first, fetch only after RESP and the return to IDLE.
      plan_data(1'b0, 32'h0000_0040, 2, 1'b0, 32'h0, 1, 32'hCAFE_F00D, el_d);
      plan_fetch(32'h0000_1000, 0, 32'h0000_0013, el_f);
      @(negedge clk);
      d_we = 1'b0; d_addr = 32'h40; d_size = 2'b10; d_signed = 1'b0; d_req = 1'b1;
      i_addr = 32'h1000; i_req = 1'b1;
      wait_done(1'b1, lat_d);
      d_req = 1'b0;
      chk("pair_data_latency", lat_d, el_d);
      wait_done(1'b0, lat_f);
      i_req = 1'b0;
      chk("pair_fetch_latency", lat_f, el_f + 1);

      data_txn(1'b0, 32'h0000_0080, 2, 1'b0, 32'h0, 100, 32'h5555_AAAA);
      data_txn(1'b1, 32'h0000_0085, 0, 1'b0, 32'h0000_00A5, 0, 32'h0);
      fetch_txn(32'h0000_0200, TMO + 3, 32'h1111_2222);

      for (int n = 0; n < 120; n++) begin
         int w;
         w = ($urandom_range(0, 24) == 0) ? TMO + 1 : int'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0)
            fetch_txn($urandom & 32'hFFFF_FFFC, w, $urandom);
         else
            data_txn(1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), $urandom, w, $urandom);
      end

      // Reset in the middle of a stalled transfer: strobes drop at once and no done follows.
      exp_bus.push_back('{1'b0, 32'h0000_0100, 4'hF, 32'h0, 0});
      slave_q.push_back('{1000, 32'h0});
      @(negedge clk);
      d_we = 1'b0; d_addr = 32'h100; d_size = 2'b10; d_req = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         seen = bus_read;
      end
      if (!seen) fail("reset_test_strobe");
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;
      #1 chk("async_reset_strobes", {bus_read, bus_write, bus_byteenable}, 0);
      d_req = 1'b0;
      @(negedge clk);
      chk("reset_timeout_err", timeout_err, 1'b0);
      chk("reset_done", {i_done, d_done}, 2'b00);
      model_tmo = 1'b0;
      exp_bus.delete();
      slave_q.delete();
      exp_resp.delete();
      reset = 1'b0;

      data_txn(1'b0, 32'h0000_0031, 0, 1'b1, 32'h0, 1, 32'h0000_7F00);
      fetch_txn(32'h0000_0400, 0, 32'h0BAD_CAFE);
      repeat (3) @(negedge clk);
      chk("exp_resp_drained", exp_resp.size(), 0);
      chk("exp_bus_drained", exp_bus.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
